muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width (even, >=8).
REQ-002 SHALL have parameter MUL_LAT, default 2, multiply latency in cycles (>=1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request; sampled with op, a, b, hilo_i.
REQ-006 op  input  3  operation: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
REQ-007 a, b  input  WIDTH each  operands; for DIV/DIVU, a is the dividend and b the divisor.
REQ-008 hilo_i  input  2*WIDTH  accumulator for MADD/MSUB family.
REQ-009 cancel  input  1  flush from exception or branch kill.
REQ-010 busy  output  1  operation in flight.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  2*WIDTH  {hi, lo}.

Function
REQ-013 States SHALL be IDLE, MUL, DIV, FIN.
REQ-014 start SHALL be accepted only in IDLE or FIN; start in MUL/DIV SHALL be ignored.
REQ-015 On acceptance, a, b, op and hilo_i SHALL be captured; later input changes SHALL have no effect.
REQ-016 busy SHALL be 1 exactly in MUL and DIV; done SHALL be 1 exactly in FIN.
REQ-017 Multiply ops: IDLE->MUL, stay MUL_LAT cycles, ->FIN; done SHALL assert MUL_LAT+1 cycles after the accepting edge.
REQ-018 MULT/MADD/MSUB signed, MULTU/MADDU/MSUBU unsigned; product is a full 2*WIDTH result.
REQ-019 MADD* result SHALL be hilo_i+product, MSUB* result hilo_i-product, both modulo 2^(2*WIDTH).
REQ-020 Divide ops: IDLE->DIV, exactly WIDTH iterations of restoring radix-2 division, ->FIN; done SHALL assert WIDTH+1 cycles after acceptance.
REQ-021 Signed divide SHALL operate on magnitudes; quotient sign = a^b sign bits; remainder sign = sign of a; truncation toward zero.
REQ-022 Divide result SHALL be hi=remainder, lo=quotient.
REQ-023 Most-negative / -1 SHALL give lo=most-negative value, hi=0.
REQ-024 Divisor zero SHALL go directly to FIN with done one cycle after acceptance, hi=a, lo=all ones.
REQ-025 FIN lasts one cycle: ->IDLE, or ->MUL/DIV if start is accepted in FIN.
REQ-026 result SHALL hold its value from FIN until the next FIN.
REQ-027 cancel SHALL force IDLE at the next edge from any state, with no done pulse and result unchanged.
REQ-028 cancel and start in the same cycle: cancel wins and start is dropped.

Reset
REQ-029 resetn low SHALL immediately force IDLE, busy=0, done=0, result=0, and clear iteration counter and datapath registers.
REQ-030 Reset mid-operation SHALL abandon the operation with no done pulse after release.
REQ-031 First start SHALL be accepted on the first edge after resetn deasserts.

Structure
REQ-032 op encodings and state encodings SHALL live in the shared defines package, beside the existing ALU op codes.
REQ-033 The divider iteration datapath SHALL be one sub-module, div_iter (partial remainder, quotient shift, counter); multiply and accumulate stay in muldiv_unit.

Verification (WIDTH=32, MUL_LAT=2)
REQ-034 MULT a=0xFFFFFFFE b=3 -> done at cycle 3, result=0xFFFFFFFF_FFFFFFFA; MULTU same operands -> 0x00000002_FFFFFFFA.
REQ-035 DIV a=0xFFFFFFF9 (-7) b=2 -> done at cycle 33, result=0xFFFFFFFF_FFFFFFFD; DIVU a=7 b=0 -> done at cycle 1, result=0x00000007_FFFFFFFF.
REQ-036 MADD hilo_i=0x00000001_00000000 a=2 b=3 -> 0x00000001_00000006; MSUB hilo_i=0 a=1 b=1 -> 0xFFFFFFFF_FFFFFFFF.
REQ-037 DIV a=0x80000000 b=0xFFFFFFFF -> result=0x00000000_80000000.
REQ-038 cancel at cycle 10 of a DIV -> busy=0 next cycle, no done, result unchanged; a following MULTU 5x5 -> 0x00000000_00000019 at cycle 3.
REQ-039 start held high through a DIV -> only one done, at cycle 33; back-to-back start in FIN -> second done exactly MUL_LAT+1 or WIDTH+1 cycles later; resetn pulse mid-MUL -> no done.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared defines: ALU op codes plus the multiply/divide unit op and state encodings.
package muldiv_unit_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned MD_OP_W  = 3;
  localparam int unsigned MD_ST_W  = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  // Bit 0 clear selects the signed flavour of every operation.
  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MADDU = 3'd5,
    MD_MSUB  = 3'd6,
    MD_MSUBU = 3'd7
  } md_op_e;

  typedef enum logic [MD_ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_acc(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_sub(input md_op_e op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring radix-2 divider iteration: partial remainder, quotient shift and step counter.
module div_iter
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_nxt_c,
  output logic [WIDTH-1:0] rem_nxt_c,
  output logic             last_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   diff_c;

  // One iteration: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted_c = {rem_q, quo_q[WIDTH-1]};
    diff_c    = shifted_c - {1'b0, dsr_q};
    rem_nxt_c = shifted_c[WIDTH-1:0];
    quo_nxt_c = {quo_q[WIDTH-2:0], 1'b0};
    if (!diff_c[WIDTH]) begin
      rem_nxt_c = diff_c[WIDTH-1:0];
      quo_nxt_c = {quo_q[WIDTH-2:0], 1'b1};
    end
    last_c = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= rem_nxt_c;
      quo_q <= quo_nxt_c;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply / multiply-accumulate / divide unit with a {hi, lo} result.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] hilo_i,
  input  logic               cancel,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned LAT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  md_state_e        state_q;
  md_op_e           op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [DW-1:0]    hilo_q;
  logic [LAT_W-1:0] lat_cnt_q;

  md_op_e           op_in_c;
  logic             accept_c;
  logic             div_load_c;
  logic             div_step_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [DW-1:0]    mul_a_c;
  logic [DW-1:0]    mul_b_c;
  logic [DW-1:0]    product_c;
  logic [DW-1:0]    mac_c;
  logic [WIDTH-1:0] quo_nxt_c;
  logic [WIDTH-1:0] rem_nxt_c;
  logic             div_last_c;
  logic [WIDTH-1:0] quo_fix_c;
  logic [WIDTH-1:0] rem_fix_c;

  // Request decode; cancel always beats a new start.
  always_comb begin
    op_in_c    = md_op_e'(op);
    accept_c   = start && !cancel && ((state_q == ST_IDLE) || (state_q == ST_FIN));
    div_load_c = accept_c && op_is_div(op_in_c) && (b != '0);
    div_step_c = (state_q == ST_DIV) && !cancel;
    a_mag_c    = (op_is_signed(op_in_c) && a[WIDTH-1]) ? -a : a;
    b_mag_c    = (op_is_signed(op_in_c) && b[WIDTH-1]) ? -b : b;
  end

  // Full-width product from the captured operands, then optional accumulate.
  always_comb begin
    mul_a_c   = op_is_signed(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    mul_b_c   = op_is_signed(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    product_c = mul_a_c * mul_b_c;
    mac_c     = product_c;
    if (op_is_acc(op_q)) begin
      mac_c = op_is_sub(op_q) ? (hilo_q - product_c) : (hilo_q + product_c);
    end
  end

  // Restore signs: quotient from a^b, remainder follows the dividend.
  always_comb begin
    quo_fix_c = quo_nxt_c;
    rem_fix_c = rem_nxt_c;
    if (op_is_signed(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) begin
      quo_fix_c = -quo_nxt_c;
    end
    if (op_is_signed(op_q) && a_q[WIDTH-1]) begin
      rem_fix_c = -rem_nxt_c;
    end
  end

  div_iter #(
    .WIDTH (WIDTH)
  ) u_div_iter (
    .clk       (clk),
    .resetn    (resetn),
    .load      (div_load_c),
    .step      (div_step_c),
    .dividend  (a_mag_c),
    .divisor   (b_mag_c),
    .quo_nxt_c (quo_nxt_c),
    .rem_nxt_c (rem_nxt_c),
    .last_c    (div_last_c)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      op_q      <= MD_MULT;
      a_q       <= '0;
      b_q       <= '0;
      hilo_q    <= '0;
      lat_cnt_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else if (cancel) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        ST_MUL: begin
          if (lat_cnt_q == LAT_W'(MUL_LAT - 1)) begin
            state_q <= ST_FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= mac_c;
          end else begin
            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          end
        end
        ST_DIV: begin
          if (div_last_c) begin
            state_q <= ST_FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= {rem_fix_c, quo_fix_c};
          end
        end
        default: begin
          // IDLE and FIN both accept a new request.
          busy <= 1'b0;
          done <= 1'b0;
          if (accept_c) begin
            op_q      <= op_in_c;
            a_q       <= a;
            b_q       <= b;
            hilo_q    <= hilo_i;
            lat_cnt_q <= '0;
            if (!op_is_div(op_in_c)) begin
              state_q <= ST_MUL;
              busy    <= 1'b1;
            end else if (b == '0) begin
              state_q <= ST_FIN;
              done    <= 1'b1;
              result  <= {a, {WIDTH{1'b1}}};
            end else begin
              state_q <= ST_DIV;
              busy    <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit (WIDTH=32, MUL_LAT=2).
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int unsigned W       = 32;
  localparam int unsigned DW      = 64;
  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned NVEC    = 14;

  logic          clk    = 1'b0;
  logic          resetn = 1'b0;
  logic          start  = 1'b0;
  logic          cancel = 1'b0;
  logic [2:0]    op     = 3'd0;
  logic [W-1:0]  a      = '0;
  logic [W-1:0]  b      = '0;
  logic [DW-1:0] hilo_i = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    md_op_e        op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [DW-1:0] hilo;
    logic [DW-1:0] exp;
    int            lat;
  } vec_t;

  vec_t vecs [NVEC];

  muldiv_unit #(
    .WIDTH   (W),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .hilo_i (hilo_i),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input md_op_e o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [DW-1:0] ih);
    start  = 1'b1;
    op     = o;
    a      = ia;
    b      = ib;
    hilo_i = ih;
  endtask

  // Counts edges from the accepting edge until done; 0 if the budget runs out.
  task automatic wait_done(input int budget, output int cyc, output logic busy1);
    cyc   = 0;
    busy1 = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        start = 1'b0;
        busy1 = busy;
      end
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic count_dones(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
  endtask

  initial begin
    int          cyc;
    int          n;
    int          dcyc;
    logic        busy1;
    logic [DW-1:0] prev;

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        64'd0,                  64'hFFFFFFFF_FFFFFFFA, 3};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFE, 32'd3,        64'd0,                  64'h00000002_FFFFFFFA, 3};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        64'd0,                  64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[3]  = '{MD_DIVU,  32'd7,        32'd0,        64'd0,                  64'h00000007_FFFFFFFF, 1};
    vecs[4]  = '{MD_MADD,  32'd2,        32'd3,        64'h00000001_00000000,  64'h00000001_00000006, 3};
    vecs[5]  = '{MD_MSUB,  32'd1,        32'd1,        64'd0,                  64'hFFFFFFFF_FFFFFFFF, 3};
    vecs[6]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 64'd0,                  64'h00000000_80000000, 33};
    vecs[7]  = '{MD_DIVU,  32'd100,      32'd7,        64'd0,                  64'h00000002_0000000E, 33};
    vecs[8]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 64'd0,                  64'h00000001_FFFFFFFD, 33};
    vecs[9]  = '{MD_MADDU, 32'd1,        32'd1,        64'hFFFFFFFF_FFFFFFFF,  64'h00000000_00000000, 3};
    vecs[10] = '{MD_MSUBU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0,                  64'h00000001_FFFFFFFF, 3};
    vecs[11] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0,                  64'h00000000_00000001, 3};
    vecs[12] = '{MD_DIV,   32'd5,        32'd0,        64'd0,                  64'h00000005_FFFFFFFF, 1};
    vecs[13] = '{MD_DIVU,  32'hFFFFFFFF, 32'd1,        64'd0,                  64'h00000000_FFFFFFFF, 33};

    // Reset values are forced asynchronously, before any clock edge.
    #2;
    check("reset busy", DW'(busy), DW'(0));
    check("reset done", DW'(done), DW'(0));
    check("reset result", result, DW'(0));
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hilo);
      wait_done(60, cyc, busy1);
      check($sformatf("v%0d latency", i), DW'(cyc), DW'(vecs[i].lat));
      check($sformatf("v%0d result", i), result, vecs[i].exp);
      check($sformatf("v%0d busy cycle1", i), DW'(busy1), DW'(vecs[i].lat > 1));
      check($sformatf("v%0d busy in fin", i), DW'(busy), DW'(0));
      @(posedge clk);
      #1;
      check($sformatf("v%0d done pulse width", i), DW'(done), DW'(0));
      check($sformatf("v%0d result hold", i), result, vecs[i].exp);
    end

    // Cancel in the middle of a divide.
    prev = vecs[NVEC-1].exp;
    issue(MD_DIV, 32'd1000, 32'd3, 64'd0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) start = 1'b0;
    end
    check("cancel busy before", DW'(busy), DW'(1));
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel busy after", DW'(busy), DW'(0));
    check("cancel done after", DW'(done), DW'(0));
    check("cancel result kept", result, prev);
    count_dones(40, n);
    check("cancel no done", DW'(n), DW'(0));
    issue(MD_MULTU, 32'd5, 32'd5, 64'd0);
    wait_done(60, cyc, busy1);
    check("post-cancel latency", DW'(cyc), DW'(3));
    check("post-cancel result", result, 64'h00000000_00000019);

    // Cancel and start in the same cycle: start is dropped.
    @(posedge clk);
    #1;
    issue(MD_MULT, 32'd9, 32'd9, 64'd0);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    check("cancel+start busy", DW'(busy), DW'(0));
    count_dones(8, n);
    check("cancel+start no done", DW'(n), DW'(0));
    check("cancel+start result", result, 64'h00000000_00000019);

    // start held high through a divide, with operands changing underneath.
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 64'd0);
    n    = 0;
    dcyc = 0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        op = MD_MULTU;
        a  = 32'd123;
        b  = 32'd5;
      end
      if (done) begin
        n++;
        if (dcyc == 0) dcyc = i;
        start = 1'b0;
      end
    end
    check("held start done count", DW'(n), DW'(1));
    check("held start done cycle", DW'(dcyc), DW'(33));
    check("held start result", result, 64'hFFFFFFFF_FFFFFFFD);

    // Back-to-back starts issued during FIN.
    issue(MD_MULT, 32'hFFFFFFFE, 32'd3, 64'd0);
    wait_done(60, cyc, busy1);
    check("b2b first latency", DW'(cyc), DW'(3));
    issue(MD_DIVU, 32'd100, 32'd7, 64'd0);
    wait_done(60, cyc, busy1);
    check("b2b div latency", DW'(cyc), DW'(33));
    check("b2b div result", result, 64'h00000002_0000000E);
    issue(MD_MULTU, 32'd5, 32'd5, 64'd0);
    wait_done(60, cyc, busy1);
    check("b2b mul latency", DW'(cyc), DW'(3));
    check("b2b mul result", result, 64'h00000000_00000019);
    @(posedge clk);
    #1;
    check("b2b done drops", DW'(done), DW'(0));

    // Reset pulse while a multiply is in flight.
    issue(MD_MULT, 32'd2, 32'd3, 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("mid-mul busy", DW'(busy), DW'(1));
    #2;
    resetn = 1'b0;
    #1;
    check("mid-mul reset busy", DW'(busy), DW'(0));
    check("mid-mul reset done", DW'(done), DW'(0));
    check("mid-mul reset result", result, DW'(0));
    @(negedge clk);
    resetn = 1'b1;
    count_dones(8, n);
    check("mid-mul reset no done", DW'(n), DW'(0));
    @(negedge clk);
    issue(MD_MULTU, 32'd5, 32'd5, 64'd0);
    wait_done(60, cyc, busy1);
    check("after reset latency", DW'(cyc), DW'(3));
    check("after reset result", result, 64'h00000000_00000019);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
